bsg_relay_credit_tx: RTL and testbench
======================================

// Module: bsg_relay_credit_tx
// PURPOSE
//  - Sending end of a credit-based relay link; pairs with a remote 2-element relay FIFO.
//  - Accepts words on an upstream valid/ready port and forwards each word as a registered, single-cycle valid beat.
//  - Replaces the remote ready with a local credit counter, so no combinational ready crosses the link.
//  - Remote side returns one credit pulse per word it dequeues.
// PARAMETERS
//  width_p    32  data word width
//  credits_p   2  remote buffer depth = initial credit count; legal range 1..15
//  cnt_w_lp    -  localparam, $clog2(credits_p+1), width of credit counter
// PORTS
//  clk_i          in   1        clock; all state updates on posedge
//  reset_n_i      in   1        synchronous reset, active-low
//  v_i            in   1        upstream word valid
//  data_i         in   width_p  upstream word
//  ready_o        out  1        upstream may transfer this cycle (v_i & ready_o = send)
//  link_v_o       out  1        registered valid beat toward remote FIFO
//  link_data_o    out  width_p  registered word toward remote FIFO
//  link_credit_i  in   1        one-cycle pulse; remote freed one entry
//  credits_o      out  cnt_w_lp current credit count (debug/perf)
//  error_o        out  1        sticky credit-overflow flag
// BEHAVIOUR
//  - Reset (reset_n_i=0 at posedge) sets all state:
//    - credits := credits_p; link_v_o := 0; link_data_o := 0; error_o := 0; credit_r := 0.
//  - ready_o is forced 0 combinationally while reset_n_i=0.
//  - ready_o = (credits != 0). Derived from registers only; never depends on v_i.
//  - Send: send = v_i & ready_o.
//    - Next cycle link_v_o=1 and link_data_o=data_i. Latency 1 cycle, one beat per send.
//  - No send: link_v_o := 0 next cycle; link_data_o holds its last value.
//  - Credit input is registered once: credit_r <= link_credit_i.
//    - The counter uses credit_r, so a returned credit is usable 2 cycles after the pulse edge.
//  - Counter update, per cycle:
//    - send & ~credit_r  -> credits-1
//    - ~send & credit_r  -> credits+1
//    - send & credit_r   -> unchanged (simultaneous event; no transient 0)
//    - neither           -> unchanged
//  - Boundary, credits==0: ready_o=0, so no send and no underflow is possible.
//  - Boundary, credit_r=1 while credits==credits_p and no send (overflow):
//    - Counter saturates at credits_p.
//    - error_o := 1 and stays 1 until reset.
//  - Back-to-back: full rate (1 word/cycle) is sustained when the credit loop round trip <= credits_p cycles.
//  - Reset mid-operation: in-flight link beat is dropped (link_v_o=0 next cycle); credits restored to credits_p.
//    - Remote side must be reset in the same cycle.
//  - No combinational path from any input to link_v_o, link_data_o, credits_o or error_o.
// STRUCTURE
//  - Shared package bsg_relay_pkg:
//    - credits_default_gp=2
//    - function credit_width(n) = $clog2(n+1)
//  - Sub-module bsg_relay_credit_counter, parameter max_p:
//    - up_i/down_i in, count_o and overflow_o out.
//    - Saturating up/down counter; reset value max_p; active-low sync reset.
//  - Top level holds the credit_r flop, the link data/valid registers and the sticky error flop.
// TESTING
//  1. Reset: hold reset_n_i=0 for 3 cycles, v_i=1.
//     -> ready_o=0, link_v_o=0, credits_o=2, error_o=0; after release ready_o=1.
//  2. Burst without credits: v_i=1 with data 0xA5A50001, 0xA5A50002, 0xA5A50003.
//     -> two beats on link in cycles t+1 and t+2; credits_o 2->1->0; ready_o=0 from t+2; third word held upstream.
//  3. Credit return: from state 0 credits, pulse link_credit_i at cycle c.
//     -> credits_o=1 at c+2, ready_o=1 at c+2; pending 0xA5A50003 appears on link at c+3.
//  4. Simultaneous: credits_o=1, send 0x0000BEEF in the same cycle credit_r=1.
//     -> credits_o stays 1, ready_o never drops, link_data_o=0x0000BEEF next cycle.
//  5. Overflow: idle with credits_o=2, pulse link_credit_i.
//     -> credits_o stays 2, error_o=1 two cycles later and stays 1 until reset.
//  6. Reset mid-burst: assert reset_n_i=0 the cycle after a send.
//     -> link_v_o=0, credits_o=2, error_o=0 next cycle; link_data_o=0.

Source files
------------

// File: rtl/bsg_relay_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bsg_relay_pkg
//  Description : Shared constants and helpers for the credit-based relay link.
//                CREDITS_DEFAULT_GP is the default remote FIFO depth.
//                credit_width(n) is the counter width needed to hold 0..n.
//  Revision    : 1.0  initial release
// ============================================================================
package bsg_relay_pkg;

    localparam int CREDITS_DEFAULT_GP = 2;

    function automatic int credit_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bsg_relay_credit_counter.sv
`default_nettype none
// ============================================================================
//  Module      : bsg_relay_credit_counter
//  Description : Saturating up/down credit counter. Resets to MAX_P.
//  Ports       : clk_i      - clock
//                reset_n_i  - synchronous reset, active-low
//                up_i       - one credit returned
//                down_i     - one credit consumed
//                count_o    - current count (registered)
//                overflow_o - an increment was attempted at MAX_P this cycle
//  Revision    : 1.0  initial release
// ============================================================================
module bsg_relay_credit_counter
    import bsg_relay_pkg::*;
#(
    parameter int MAX_P    = CREDITS_DEFAULT_GP,
    parameter int CNT_W_LP = credit_width(MAX_P)
) (
    input  logic                clk_i,
    input  logic                reset_n_i,
    input  logic                up_i,
    input  logic                down_i,
    output logic [CNT_W_LP-1:0] count_o,
    output logic                overflow_o
);

    localparam logic [CNT_W_LP-1:0] c_max = CNT_W_LP'(MAX_P);

    logic [CNT_W_LP-1:0] r_count;
    logic                w_inc;
    logic                w_dec;

    // Simultaneous up and down cancel, so no transient change is ever seen.
    assign w_inc = up_i & ~down_i;
    assign w_dec = down_i & ~up_i;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_count <= c_max;
        end else if (w_inc && (r_count != c_max)) begin
            r_count <= r_count + 1'b1;
        end else if (w_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign count_o    = r_count;
    assign overflow_o = w_inc & (r_count == c_max);

endmodule
`default_nettype wire

// File: rtl/bsg_relay_credit_tx.sv
`default_nettype none
// ============================================================================
//  Module      : bsg_relay_credit_tx
//  Description : Sending end of a credit-based relay link. Upstream words are
//                accepted while credits remain and forwarded as registered
//                single-cycle beats. Credits returned by the remote FIFO are
//                registered once before they reach the counter.
//  Ports       : clk_i         - clock
//                reset_n_i     - synchronous reset, active-low
//                v_i / data_i  - upstream word
//                ready_o       - upstream may transfer (credits != 0)
//                link_v_o      - registered beat valid toward remote FIFO
//                link_data_o   - registered beat data
//                link_credit_i - one-cycle pulse, remote freed one entry
//                credits_o     - current credit count
//                error_o       - sticky credit-overflow flag
//  Revision    : 1.0  initial release
// ============================================================================
module bsg_relay_credit_tx
    import bsg_relay_pkg::*;
#(
    parameter int WIDTH_P   = 32,
    parameter int CREDITS_P = CREDITS_DEFAULT_GP,
    parameter int CNT_W_LP  = credit_width(CREDITS_P)
) (
    input  logic                clk_i,
    input  logic                reset_n_i,
    input  logic                v_i,
    input  logic [WIDTH_P-1:0]  data_i,
    output logic                ready_o,
    output logic                link_v_o,
    output logic [WIDTH_P-1:0]  link_data_o,
    input  logic                link_credit_i,
    output logic [CNT_W_LP-1:0] credits_o,
    output logic                error_o
);

    logic                r_credit;
    logic                r_link_v;
    logic [WIDTH_P-1:0]  r_link_data;
    logic                r_error;
    logic [CNT_W_LP-1:0] w_credits;
    logic                w_overflow;
    logic                w_send;

    // Ready comes from the counter register only; the reset term keeps the
    // upstream from handing over a word that reset would silently drop.
    assign ready_o = reset_n_i & (w_credits != '0);
    assign w_send  = v_i & ready_o;

    bsg_relay_credit_counter #(
        .MAX_P    (CREDITS_P),
        .CNT_W_LP (CNT_W_LP)
    ) u_counter (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .up_i       (r_credit),
        .down_i     (w_send),
        .count_o    (w_credits),
        .overflow_o (w_overflow)
    );

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_credit    <= 1'b0;
            r_link_v    <= 1'b0;
            r_link_data <= '0;
            r_error     <= 1'b0;
        end else begin
            r_credit <= link_credit_i;
            r_link_v <= w_send;
            if (w_send) begin
                r_link_data <= data_i;
            end
            if (w_overflow) begin
                r_error <= 1'b1;
            end
        end
    end

    assign link_v_o    = r_link_v;
    assign link_data_o = r_link_data;
    assign credits_o   = w_credits;
    assign error_o     = r_error;

endmodule
`default_nettype wire

// File: tb/tb_bsg_relay_credit_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bsg_relay_credit_tx
//  Description : Self-checking bench for bsg_relay_credit_tx. Directed steps
//                followed by a randomized phase against a remote FIFO model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bsg_relay_credit_tx;

    localparam int c_w  = 32;
    localparam int c_cr = 2;
    localparam int c_cw = $clog2(c_cr + 1);

    logic            clk = 1'b0;
    logic            rst_n;
    logic            v;
    logic [c_w-1:0]  data;
    logic            ready;
    logic            link_v;
    logic [c_w-1:0]  link_data;
    logic            link_credit;
    logic [c_cw-1:0] credits;
    logic            error;

    always #5 clk = ~clk;

    bsg_relay_credit_tx #(
        .WIDTH_P   (c_w),
        .CREDITS_P (c_cr)
    ) dut (
        .clk_i         (clk),
        .reset_n_i     (rst_n),
        .v_i           (v),
        .data_i        (data),
        .ready_o       (ready),
        .link_v_o      (link_v),
        .link_data_o   (link_data),
        .link_credit_i (link_credit),
        .credits_o     (credits),
        .error_o       (error)
    );

    int checks = 0;
    int errors = 0;

    // Reference state: credits available, credit pulse seen last cycle,
    // expected link beat, sticky error.
    int             m_credits = c_cr;
    bit             m_cr      = 1'b0;
    bit             m_v       = 1'b0;
    logic [c_w-1:0] m_data    = '0;
    bit             m_err     = 1'b0;
    logic [c_w-1:0] sent_q[$];
    int             remote_occ = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle with the inputs as currently driven.
    task automatic tick();
        bit s;
        int nxt;
        logic [c_w-1:0] front;
        #1;
        chk("ready", ready, (rst_n && m_credits != 0));
        s = rst_n && v && (m_credits != 0);
        if (s) sent_q.push_back(data);
        if (!rst_n) begin
            m_credits = c_cr; m_cr = 0; m_v = 0; m_data = '0; m_err = 0;
            sent_q.delete();
        end else begin
            // Net credit change: minus one per send, plus one per delayed return.
            nxt = m_credits - int'(s) + int'(m_cr);
            if (nxt > c_cr) begin
                nxt   = c_cr;
                m_err = 1;
            end
            m_credits = nxt;
            m_v       = s;
            if (s) m_data = data;
            m_cr      = link_credit;
        end
        @(posedge clk);
        #1;
        chk("link_v", link_v, m_v);
        chk("link_data", link_data, m_data);
        chk("credits", credits, m_credits);
        chk("error", error, m_err);
        if (link_v) begin
            chk("sb_pending", (sent_q.size() != 0), 1);
            if (sent_q.size() != 0) begin
                front = sent_q.pop_front();
                chk("sb_order", link_data, front);
            end
        end
    endtask

    initial begin
        rst_n = 0; v = 1; data = 32'h1234_5678; link_credit = 0;

        // 1. Reset held three cycles with v_i high.
        repeat (3) tick();
        chk("rst_credits", credits, 2);
        chk("rst_link_v", link_v, 0);
        chk("rst_error", error, 0);
        rst_n = 1; v = 0;
        #1;
        chk("ready_after_rst", ready, 1);

        // 2. Burst of three words with only two credits.
        v = 1; data = 32'hA5A5_0001; tick();
        data = 32'hA5A5_0002; tick();
        chk("burst_credits0", credits, 0);
        data = 32'hA5A5_0003; tick();
        chk("burst_held", ready, 0);

        // 3. Credit return unblocks the pending word.
        link_credit = 1; tick();
        link_credit = 0; tick();
        chk("ret_credits1", credits, 1);
        tick();
        chk("ret_beat", link_data, 32'hA5A5_0003);
        v = 0; tick();

        // Bring credits back to 1.
        link_credit = 1; tick();
        link_credit = 0; tick(); tick();

        // 4. Send in the same cycle the returned credit takes effect.
        link_credit = 1; tick();
        link_credit = 0; v = 1; data = 32'h0000_BEEF; tick();
        chk("simul_credits", credits, 1);
        chk("simul_data", link_data, 32'h0000_BEEF);
        v = 0; tick();

        // Back to full credits.
        link_credit = 1; tick();
        link_credit = 0; tick(); tick();

        // 5. Spurious credit at full count.
        link_credit = 1; tick();
        link_credit = 0; tick();
        chk("ovf_error", error, 1);
        chk("ovf_sat", credits, 2);
        repeat (3) tick();

        // 6. Reset the cycle after a send.
        v = 1; data = 32'hCAFE_0001; tick();
        rst_n = 0; v = 0; tick();
        chk("mid_rst_v", link_v, 0);
        chk("mid_rst_data", link_data, 0);
        chk("mid_rst_credits", credits, 2);
        chk("mid_rst_error", error, 0);
        rst_n = 1;

        // 7. Randomized traffic against a remote FIFO that dequeues at random.
        remote_occ = 0;
        for (int i = 0; i < 400; i++) begin
            v    = ($urandom_range(0, 3) != 0);
            data = $urandom;
            link_credit = 0;
            if (remote_occ > 0 && $urandom_range(0, 2) != 0) begin
                link_credit = 1;
                remote_occ--;
            end
            tick();
            if (link_v) remote_occ++;
            chk("remote_no_overrun", (remote_occ <= c_cr), 1);
        end
        link_credit = 0; v = 0;
        repeat (4) tick();
        chk("rand_no_error", error, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
